uartprobe_uart_rx: RTL

- UART receive stage that sits directly upstream of the probe command FSM.
- Deserialises 8N1 frames from the uart_rx pin and buffers them in a 2-entry FIFO.
- Presents bytes on a valid/ready interface matching the probe's rx_valid/rx_data/rx_ready inputs.
- Flags framing and overrun errors for debug.

---
 rtl/uartprobe_uart_rx.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uartprobe_uart_rx.sv
// UART 8N1 receiver for the probe command path: two-flop synchroniser, bit FSM,
// 2-entry output FIFO with valid/ready handshake, sticky framing/overrun flags.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low (start edge)
// START     | half-bit wait, confirm start bit is still low (else glitch)
// DATA      | sample 8 data bits LSB first at bit centres
// STOP      | sample stop bit: high pushes byte, low flags framing error
// WAIT_HIGH | framing error/break: hold off until the line returns high
module uartprobe_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  logic        rx_meta_q;
  logic        rx_s_q;

  state_e      state_q,   state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q,   shift_d;

  logic        push;
  logic        frame_set;

  logic [7:0]  head_q,    head_d;
  logic [7:0]  tail_q,    tail_d;
  logic [1:0]  count_q,   count_d;
  logic        pop;
  logic        overrun_set;

  logic        frame_err_q, frame_err_d;
  logic        overrun_q,   overrun_d;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // head_q is the presented byte; tail_q only meaningful when count_q == 2
  assign pop = (count_q != 2'd0) && rx_ready;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overrun_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = shift_q;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_d  = shift_q;
          count_d = 2'd2;
        end else begin
          overrun_set = 1'b1;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end else begin
          head_d  = '0;
          count_d = 2'd0;
        end
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = shift_q;
        end else begin
          head_d = shift_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // a set event in the same cycle as err_clr keeps the flag high
  always_comb begin
    frame_err_d = frame_set   ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overrun_d   = overrun_set ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_valid  = (count_q != 2'd0);
  assign rx_data   = head_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
